pipeline_ctrl: RTL and testbench

Sequencer for the five-stage MIPS pipeline. It drives the PC enable and the IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes, and the next-PC select. It resolves load-use hazards, taken branches and jumps, and multi-cycle data-memory waits. It sits beside the pipeline register bank and the control FSM, and is the only source of the stage enables.

---
 rtl/pipeline_ctrl_pkg.sv | 21 ++
 rtl/pipeline_ctrl_if.sv | 46 ++++
 rtl/pipeline_ctrl_hazard_detect.sv | 17 +
 rtl/pipeline_ctrl.sv | 167 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings for the five-stage pipeline sequencer:
// FSM states, next-PC select codes and the hard-wired zero register.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    HALT     = 2'b00,
    RUN      = 2'b01,
    MEM_WAIT = 2'b10,
    ERROR    = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'b00,
    PCSEL_BR  = 2'b01,
    PCSEL_JMP = 2'b10
  } pcsel_t;

  // Register $0 is hard-wired to zero and can never carry a dependency.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle between the pipeline sequencer and the datapath/register bank.
// master: the sequencer (drives enables, flushes, pc_sel, status).
// slave : the datapath side (drives decode/hazard/memory status).
interface pipeline_ctrl_if #(parameter int CNT_W = 16);

  logic             run;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_jump;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic             mem_branch_taken;
  logic             mem_access;
  logic             dmem_ready;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_mem_flush;
  logic [1:0]       pc_sel;
  logic             mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    input  run, id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           mem_branch_taken, mem_access, dmem_ready,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, mem_err,
           state_o, stall_cnt, flush_cnt
  );

  modport slave (
    output run, id_rs, id_rt, id_uses_rt, id_jump, ex_mem_read, ex_rt,
           mem_branch_taken, mem_access, dmem_ready,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, mem_err,
           state_o, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use compare: the load in ID/EX writes a register
// that the instruction in IF/ID reads. $0 is never a hazard source.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt,
  output logic       load_use
);

  assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: sole source of the stage enables,
// flushes and next-PC select. Handles load-use stalls, taken branches,
// jumps and multi-cycle data-memory waits with a timeout.
// Optional build macro: PIPE_PERF_CNT_EN (stall/flush performance counters).
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            reset,
  pipeline_ctrl_if.master bus
);

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic [CNT_W-1:0] wait_inc_s;
  logic             load_use_s;

  logic             pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s;
  logic             if_id_flush_s, id_ex_flush_s, ex_mem_flush_s;
  pcsel_t           pc_sel_s;

  hazard_detect u_hazard (
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .id_uses_rt  (bus.id_uses_rt),
    .ex_mem_read (bus.ex_mem_read),
    .ex_rt       (bus.ex_rt),
    .load_use    (load_use_s)
  );

  assign wait_inc_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};

  // State register and memory-wait counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= HALT;
      wait_cnt_r <= '0;
    end else begin
      case (state_r)
        HALT: begin
          if (bus.run) state_r <= RUN;
        end
        RUN: begin
          if (!bus.run) begin
            state_r <= HALT;
          end else if (bus.mem_access && !bus.dmem_ready) begin
            state_r    <= MEM_WAIT;
            wait_cnt_r <= '0;
          end
        end
        MEM_WAIT: begin
          if (!bus.run) begin
            state_r    <= HALT;
            wait_cnt_r <= '0;
          end else if (bus.dmem_ready) begin
            state_r    <= RUN;
            wait_cnt_r <= '0;
          end else if (wait_inc_s == CNT_W'(MEM_TIMEOUT)) begin
            state_r    <= ERROR;
            wait_cnt_r <= '0;
          end else begin
            wait_cnt_r <= wait_inc_s;
          end
        end
        ERROR: begin
          state_r <= ERROR;
        end
        default: begin
          state_r    <= HALT;
          wait_cnt_r <= '0;
        end
      endcase
    end
  end

  // Stage enables, flushes and next-PC select from state and hazard inputs.
  always_comb begin
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    id_ex_en_s     = 1'b0;
    ex_mem_en_s    = 1'b0;
    mem_wb_en_s    = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_flush_s  = 1'b0;
    ex_mem_flush_s = 1'b0;
    pc_sel_s       = PCSEL_SEQ;
    case (state_r)
      RUN: begin
        if (!bus.run) begin
          pc_en_s = 1'b0;
        end else if (bus.mem_access && !bus.dmem_ready) begin
          // Hold the front; MEM/WB takes a bubble while the access waits.
          mem_wb_en_s = 1'b1;
        end else if (bus.mem_branch_taken) begin
          // Branch beats jump and load-use: everything younger is wrong-path.
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
          {if_id_flush_s, id_ex_flush_s, ex_mem_flush_s}             = 3'b111;
          pc_sel_s = PCSEL_BR;
        end else if (bus.id_jump) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
          if_id_flush_s = 1'b1;
          pc_sel_s      = PCSEL_JMP;
        end else if (load_use_s) begin
          // One bubble into ID/EX while PC and IF/ID hold.
          {id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 3'b111;
          id_ex_flush_s = 1'b1;
        end else begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
        end
      end
      MEM_WAIT: begin
        if (bus.run && bus.dmem_ready) begin
          {pc_en_s, if_id_en_s, id_ex_en_s, ex_mem_en_s, mem_wb_en_s} = 5'b11111;
        end else begin
          pc_en_s = 1'b0;
        end
      end
      default: begin
        pc_en_s = 1'b0;
      end
    endcase
  end

  assign bus.pc_en        = pc_en_s;
  assign bus.if_id_en     = if_id_en_s;
  assign bus.id_ex_en     = id_ex_en_s;
  assign bus.ex_mem_en    = ex_mem_en_s;
  assign bus.mem_wb_en    = mem_wb_en_s;
  assign bus.if_id_flush  = if_id_flush_s;
  assign bus.id_ex_flush  = id_ex_flush_s;
  assign bus.ex_mem_flush = ex_mem_flush_s;
  assign bus.pc_sel       = pc_sel_s;
  assign bus.state_o      = state_r;
  // ERROR is left only through reset, so the flag is sticky by construction.
  assign bus.mem_err      = (state_r == ERROR);

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (((state_r == RUN) || (state_r == MEM_WAIT)) && !pc_en_s &&
          (stall_cnt_r != {CNT_W{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (if_id_flush_s && (flush_cnt_r != {CNT_W{1'b1}})) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.stall_cnt = stall_cnt_r;
  assign bus.flush_cnt = flush_cnt_r;
`else
  assign bus.stall_cnt = '0;
  assign bus.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a table of RUN-state vectors plus
// hand-written sequences for reset, memory wait, timeout and counters.
module tb_pipeline_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_bad;

  pipeline_ctrl_if #(.CNT_W(16)) bus ();

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string      name;
    logic [4:0] rs, rt, ex_rt;
    logic       uses_rt, jump, rd, br, acc, rdy;
    logic [4:0] exp_en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [2:0] exp_fl;   // {if_id, id_ex, ex_mem}
    logic [1:0] exp_sel;
  } vec_t;

  vec_t tbl[10];

  function automatic logic [4:0] en_vec();
    return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
  endfunction

  function automatic logic [2:0] fl_vec();
    return {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic run, input logic [4:0] rs, input logic [4:0] rt,
                        input logic uses, input logic jump, input logic rd,
                        input logic [4:0] ex_rt, input logic br, input logic acc,
                        input logic rdy);
    @(posedge clk);
    #1;
    bus.run = run; bus.id_rs = rs; bus.id_rt = rt; bus.id_uses_rt = uses;
    bus.id_jump = jump; bus.ex_mem_read = rd; bus.ex_rt = ex_rt;
    bus.mem_branch_taken = br; bus.mem_access = acc; bus.dmem_ready = rdy;
  endtask

  task automatic idle(input logic run);
    set_in(run, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.run = 1'b0; bus.id_rs = 5'd0; bus.id_rt = 5'd0; bus.id_uses_rt = 1'b0;
    bus.id_jump = 1'b0; bus.ex_mem_read = 1'b0; bus.ex_rt = 5'd0;
    bus.mem_branch_taken = 1'b0; bus.mem_access = 1'b0; bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Leave HALT: run is raised, the next edge enters RUN.
  task automatic go_run();
    idle(1'b1);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    reset = 1'b0;

    //             name          rs     rt     ex_rt  use  jmp  rd   br   acc  rdy  en        fl      sel
    tbl[0] = '{"idle",        5'd0,  5'd0,  5'd0,  1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11111, 3'b000, 2'b00};
    tbl[1] = '{"lu_rs",       5'd8,  5'd1,  5'd8,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 5'b00111, 3'b010, 2'b00};
    tbl[2] = '{"lu_r0",       5'd0,  5'd0,  5'd0,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 5'b11111, 3'b000, 2'b00};
    tbl[3] = '{"lu_rt",       5'd3,  5'd9,  5'd9,  1'b1,1'b0,1'b1,1'b0,1'b0,1'b0, 5'b00111, 3'b010, 2'b00};
    tbl[4] = '{"rt_unused",   5'd3,  5'd9,  5'd9,  1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 5'b11111, 3'b000, 2'b00};
    tbl[5] = '{"no_load",     5'd8,  5'd8,  5'd8,  1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 5'b11111, 3'b000, 2'b00};
    tbl[6] = '{"br_over_lu",  5'd8,  5'd1,  5'd8,  1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 5'b11111, 3'b111, 2'b01};
    tbl[7] = '{"jump",        5'd2,  5'd4,  5'd0,  1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 5'b11111, 3'b100, 2'b10};
    tbl[8] = '{"br_over_jmp", 5'd2,  5'd4,  5'd0,  1'b0,1'b1,1'b0,1'b1,1'b0,1'b0, 5'b11111, 3'b111, 2'b01};
    tbl[9] = '{"jmp_over_lu", 5'd8,  5'd1,  5'd8,  1'b0,1'b1,1'b1,1'b0,1'b1,1'b1, 5'b11111, 3'b100, 2'b10};

    // Reset state: everything quiet, HALT.
    do_reset();
    #1;
    check("rst_state", 16'(bus.state_o), 16'h0);
    check("rst_en",    16'(en_vec()),    16'h0);
    check("rst_err",   16'(bus.mem_err), 16'h0);
    check("rst_stall", bus.stall_cnt,    16'h0);
    check("rst_flush", bus.flush_cnt,    16'h0);

    // Table of single-cycle RUN decisions.
    go_run();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b1, tbl[i].rs, tbl[i].rt, tbl[i].uses_rt, tbl[i].jump, tbl[i].rd,
             tbl[i].ex_rt, tbl[i].br, tbl[i].acc, tbl[i].rdy);
      @(negedge clk);
      check({tbl[i].name, "_en"},    16'(en_vec()),     16'(tbl[i].exp_en));
      check({tbl[i].name, "_fl"},    16'(fl_vec()),     16'(tbl[i].exp_fl));
      check({tbl[i].name, "_sel"},   16'(bus.pc_sel),   16'(tbl[i].exp_sel));
      check({tbl[i].name, "_state"}, 16'(bus.state_o), 16'h1);
    end

    // Load-use bubble lasts exactly one cycle.
    set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("lu_stall_en", 16'(en_vec()), 16'h07);
    idle(1'b1);
    @(negedge clk);
    check("lu_after_en", 16'(en_vec()), 16'h1f);

    // Asynchronous reset in the middle of RUN.
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", 16'(bus.state_o), 16'h0);
    check("mid_rst_en",    16'(en_vec()),    16'h0);
    check("mid_rst_fl",    16'({fl_vec(), bus.pc_sel}), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("post_rel_en", 16'(en_vec()), 16'h0);
    for (int i = 0; i < 2; i++) begin
      if (bus.state_o != 2'b01) begin
        @(posedge clk);
        #1;
      end
    end
    check("post_rel_run", 16'(bus.state_o), 16'h1);

    // Memory wait: two cycles not ready, then ready.
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("mw_enter_en",    16'(en_vec()),    16'h01);
    check("mw_enter_state", 16'(bus.state_o), 16'h1);
    for (int i = 0; i < 2; i++) begin
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("mw_wait_state", 16'(bus.state_o), 16'h2);
      check("mw_wait_en",    16'(en_vec()),    16'h00);
    end
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    check("mw_ready_state", 16'(bus.state_o), 16'h2);
    check("mw_ready_en",    16'(en_vec()),    16'h1f);
    idle(1'b1);
    @(negedge clk);
    check("mw_back_state", 16'(bus.state_o), 16'h1);
    check("mw_back_en",    16'(en_vec()),    16'h1f);

    // Timeout: four MEM_WAIT cycles, then sticky ERROR.
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("to_wait_state", 16'(bus.state_o), 16'h2);
      check("to_wait_err",   16'(bus.mem_err), 16'h0);
    end
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("to_err_state", 16'(bus.state_o), 16'h3);
    check("to_err_flag",  16'(bus.mem_err), 16'h1);
    idle(1'b0);
    idle(1'b1);
    @(negedge clk);
    check("err_sticky_state", 16'(bus.state_o), 16'h3);
    check("err_sticky_flag",  16'(bus.mem_err), 16'h1);
    check("err_sticky_en",    16'(en_vec()),    16'h0);
    do_reset();
    #1;
    check("err_cleared", 16'(bus.mem_err), 16'h0);

    // run dropped during MEM_WAIT abandons the access.
    go_run();
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    set_in(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check("mw_halt_state", 16'(bus.state_o), 16'h2);
    check("mw_halt_en",    16'(en_vec()),    16'h0);
    idle(1'b0);
    @(negedge clk);
    check("mw_halted", 16'(bus.state_o), 16'h0);

    // Performance counters: two load-use stalls and one jump.
    do_reset();
    go_run();
    set_in(1'b1, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    set_in(1'b1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    set_in(1'b1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(1'b1);
    @(negedge clk);
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall", bus.stall_cnt, 16'd2);
    check("perf_flush", bus.flush_cnt, 16'd1);
`else
    check("perf_stall_off", bus.stall_cnt, 16'd0);
    check("perf_flush_off", bus.flush_cnt, 16'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
